// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg: state encoding, registered-output bundle and default cycle
// constants shared by the PLL reset sequencer and its bench.
package pll_reset_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  // Everything the sequencer presents to the board, apart from the retry count
  typedef struct packed {
    logic pll_reset;
    logic sys_rst;
    logic ready;
    logic fault;
  } seq_out_t;

  localparam int DEF_PLL_RESET_CYCLES    = 32;
  localparam int DEF_STABLE_CYCLES       = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 27000;  // 1 ms at 27 MHz
  localparam int DEF_MAX_RETRIES         = 7;
  localparam int RETRY_W                 = 3;

  localparam seq_out_t OUT_RESET = '{pll_reset: 1'b1, sys_rst: 1'b1, ready: 1'b0, fault: 1'b0};

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Output levels implied by a state; applied to the next state so the
  // registered outputs change on the same edge as the state register
  function automatic seq_out_t decode_out(input state_e s);
    seq_out_t o;
    o.pll_reset = (s == RESET_PLL) || (s == FAULT);
    o.sys_rst   = (s != RUN);
    o.ready     = (s == RUN);
    o.fault     = (s == FAULT);
    return o;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: PLL control/status bundle. The sequencer is the
// master (drives PLL reset and system reset); the board/PLL side is the slave.
interface pll_reset_sequencer_if;
  import pll_reset_pkg::*;

  logic               pll_lock;
  logic               pll_reset;
  logic               sys_rst;
  logic               ready;
  logic               fault;
  logic [RETRY_W-1:0] retries;

  modport master (
    input  pll_lock,
    output pll_reset, sys_rst, ready, fault, retries
  );

  modport slave (
    output pll_lock,
    input  pll_reset, sys_rst, ready, fault, retries
  );
endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// sync_2ff: generic two-flop synchronizer with a synchronous reset value.
// Meant for slow level signals crossing into i_clk; no glitch filtering.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // first stage may go metastable; second stage gives it a full cycle to settle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: brings the rPLL out of reset, waits for a lock that
// stays up for STABLE_CYCLES, then releases the system reset. Lock loss
// re-asserts system reset and restarts the PLL.
// Build option: define PLL_LOCK_TIMEOUT_EN to compile in the per-attempt
// lock timeout, retry counting and the sticky FAULT state.
module pll_reset_sequencer
  import pll_reset_pkg::*;
#(
  parameter int PLL_RESET_CYCLES    = DEF_PLL_RESET_CYCLES,
  parameter int STABLE_CYCLES       = DEF_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  pll_reset_sequencer_if.master pll_if
);

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int MAX_CNT = max2(max2(PLL_RESET_CYCLES, STABLE_CYCLES), LOCK_TIMEOUT_CYCLES);
`else
  localparam int MAX_CNT = max2(PLL_RESET_CYCLES, STABLE_CYCLES);
`endif
  localparam int CNT_W = $clog2(MAX_CNT) + 1;

  // A bad parameter set shows up as g_cfg_invalid in the elaborated hierarchy
  if (PLL_RESET_CYCLES < 2 || STABLE_CYCLES < 1 ||
      LOCK_TIMEOUT_CYCLES < 1 || MAX_RETRIES < 1) begin : g_cfg_invalid
  end

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  seq_out_t           r_out;
  seq_out_t           w_out_nxt;
  logic               w_lock_s;
`ifdef PLL_LOCK_TIMEOUT_EN
  logic [RETRY_W-1:0] r_retries;
  logic [RETRY_W-1:0] w_retries_nxt;
  logic               w_fail;
`endif

  // raw LOCK is asynchronous to the crystal clock; only w_lock_s is used below
  sync_2ff #(.WIDTH(1), .RST_VAL(1'b0)) u_lock_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (pll_if.pll_lock),
    .o_q   (w_lock_s)
  );

  // next state, shared counter, retry accounting and next output levels
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
`ifdef PLL_LOCK_TIMEOUT_EN
    w_retries_nxt = r_retries;
    w_fail        = 1'b0;
`endif
    case (r_state)
      RESET_PLL: begin
        if (r_cnt == CNT_W'(PLL_RESET_CYCLES - 1)) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end
`ifdef PLL_LOCK_TIMEOUT_EN
        else if (r_cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          w_fail = 1'b1;
        end
`else
        else begin
          // waiting forever: park the counter so it can never wrap
          w_cnt_nxt = r_cnt;
        end
`endif
      end
      STABLE: begin
        // a dropout just restarts acquisition; it is not a failed attempt
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      end
      RUN: begin
        w_cnt_nxt = r_cnt;
        // lock loss restarts the PLL without touching the retry count
        if (!w_lock_s) begin
          w_state_nxt = RESET_PLL;
          w_cnt_nxt   = '0;
        end
      end
`ifdef PLL_LOCK_TIMEOUT_EN
      FAULT: begin
        w_cnt_nxt = r_cnt;
      end
`endif
      default: begin
        w_state_nxt = RESET_PLL;
        w_cnt_nxt   = '0;
      end
    endcase

`ifdef PLL_LOCK_TIMEOUT_EN
    if (w_fail) begin
      w_cnt_nxt = '0;
      if (int'(r_retries) + 1 >= MAX_RETRIES) begin
        w_state_nxt = FAULT;
      end else begin
        w_state_nxt   = RESET_PLL;
        w_retries_nxt = (r_retries == '1) ? r_retries : r_retries + RETRY_W'(1);
      end
    end
`endif

    w_out_nxt = decode_out(w_state_nxt);
`ifndef PLL_LOCK_TIMEOUT_EN
    w_out_nxt.fault = 1'b0;
`endif
  end

  // state, counter and output registers; rst wins from any state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RESET_PLL;
      r_cnt   <= '0;
      r_out   <= OUT_RESET;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
    end
  end

`ifdef PLL_LOCK_TIMEOUT_EN
  // failed-attempt count, cleared only by rst
  always_ff @(posedge i_clk) begin
    if (i_rst) r_retries <= '0;
    else       r_retries <= w_retries_nxt;
  end

  assign pll_if.retries = r_retries;
`else
  assign pll_if.retries = '0;
`endif

  assign pll_if.pll_reset = r_out.pll_reset;
  assign pll_if.sys_rst   = r_out.sys_rst;
  assign pll_if.ready     = r_out.ready;
  assign pll_if.fault     = r_out.fault;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: table vectors, hand-written corner sequences and a
// randomized lock pattern, all checked cycle by cycle against a run-length
// model of the sequencing rules.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;
  localparam int P = 4;
  localparam int S = 8;
  localparam int T = 20;
  localparam int M = 3;
`ifdef PLL_LOCK_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  pll_reset_sequencer_if pif();

  pll_reset_sequencer #(
    .PLL_RESET_CYCLES(P), .STABLE_CYCLES(S),
    .LOCK_TIMEOUT_CYCLES(T), .MAX_RETRIES(M)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .pll_if (pif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: phases and run lengths, not the DUT's state encoding
  localparam int MP_RST = 0, MP_ACQ = 1, MP_RUN = 2, MP_FLT = 3;
  int m_ph, m_rcnt, m_run, m_wait, m_retries;
  bit m_s1, m_s2;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_enter_reset();
    m_ph   = MP_RST;
    m_rcnt = 0;
  endtask

  task automatic model_fail();
    if (m_retries + 1 >= M) m_ph = MP_FLT;
    else begin
      m_retries = (m_retries >= 7) ? 7 : m_retries + 1;
      model_enter_reset();
    end
  endtask

  task automatic model_edge(input bit r, input bit l);
    bit ls;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_retries = 0; m_run = 0; m_wait = 0;
      model_enter_reset();
      return;
    end
    ls = m_s2; m_s2 = m_s1; m_s1 = l;
    case (m_ph)
      MP_RST: begin
        m_rcnt++;
        if (m_rcnt == P) begin m_ph = MP_ACQ; m_run = 0; m_wait = 0; end
      end
      MP_ACQ: begin
        if (ls) begin
          m_run++; m_wait = 0;
          if (m_run == S + 1) m_ph = MP_RUN;
        end else if (m_run > 0) begin
          m_run = 0; m_wait = 0;
        end else begin
          m_wait++;
          if (TIMEOUT_EN && m_wait == T) model_fail();
        end
      end
      MP_RUN: if (!ls) model_enter_reset();
      default: ;
    endcase
  endtask

  // one clock: drive at negedge, edge, then compare at the next negedge
  task automatic step(input bit r, input bit l);
    rst = r;
    pif.pll_lock = l;
    @(posedge clk);
    model_edge(r, l);
    @(negedge clk);
    chk("mdl_pll_reset", pif.pll_reset, (m_ph == MP_RST) || (m_ph == MP_FLT));
    chk("mdl_sys_rst",   pif.sys_rst,   m_ph != MP_RUN);
    chk("mdl_ready",     pif.ready,     m_ph == MP_RUN);
    chk("mdl_fault",     pif.fault,     m_ph == MP_FLT);
    chk("mdl_retries",   pif.retries,   m_retries);
  endtask

  typedef struct {
    bit rst; bit lock; int n;
    bit e_prst; bit e_srst; bit e_rdy; int e_ret;
  } vec_t;
  vec_t vt[13];

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t1, t2, tf, cyc, len;
    bit lv;
    pif.pll_lock = 1'b0;

    // clean lock (rise 5 cycles after pll_reset falls), lock loss, relock
    vt[0]  = '{1, 0, 1,  1, 1, 0, 0};
    vt[1]  = '{0, 0, 3,  1, 1, 0, 0};
    vt[2]  = '{0, 0, 1,  0, 1, 0, 0};
    vt[3]  = '{0, 0, 4,  0, 1, 0, 0};
    vt[4]  = '{0, 1, 10, 0, 1, 0, 0};
    vt[5]  = '{0, 1, 1,  0, 0, 1, 0};
    vt[6]  = '{0, 1, 5,  0, 0, 1, 0};
    vt[7]  = '{0, 0, 2,  0, 0, 1, 0};
    vt[8]  = '{0, 0, 1,  1, 1, 0, 0};
    vt[9]  = '{0, 0, 3,  1, 1, 0, 0};
    vt[10] = '{0, 1, 1,  0, 1, 0, 0};
    vt[11] = '{0, 1, 9,  0, 1, 0, 0};
    vt[12] = '{0, 1, 1,  0, 0, 1, 0};
    for (int i = 0; i < 13; i++) begin
      for (int j = 0; j < vt[i].n; j++) begin
        step(vt[i].rst, vt[i].lock);
        chk($sformatf("vec%0d_pll_reset", i), pif.pll_reset, vt[i].e_prst);
        chk($sformatf("vec%0d_sys_rst", i),   pif.sys_rst,   vt[i].e_srst);
        chk($sformatf("vec%0d_ready", i),     pif.ready,     vt[i].e_rdy);
        chk($sformatf("vec%0d_fault", i),     pif.fault,     0);
        chk($sformatf("vec%0d_retries", i),   pif.retries,   vt[i].e_ret);
      end
    end

    // lock chatter: 3 high, 2 low, then steady; release timed from final rise
    step(1, 0);
    n = 0;
    while (pif.pll_reset && n < 20) begin step(0, 0); n++; end
    chk("chatter_prst_len", n, P);
    repeat (3) step(0, 1);
    repeat (2) step(0, 0);
    step(0, 1);
    n = 0;
    while (pif.sys_rst && n < 100) begin step(0, 1); n++; end
    chk("chatter_latency", n, 2 + S);
    chk("chatter_retries", pif.retries, 0);

    // rst for one cycle while in STABLE
    step(1, 0);
    n = 0;
    while (pif.pll_reset && n < 20) begin step(0, 0); n++; end
    repeat (5) step(0, 1);
    chk("midrst_pre_sys_rst", pif.sys_rst, 1);
    step(1, 1);
    chk("midrst_pll_reset", pif.pll_reset, 1);
    chk("midrst_sys_rst", pif.sys_rst, 1);
    n = 1;
    while (pif.pll_reset && n < 20) begin step(0, 1); n++; end
    chk("midrst_prst_len", n, P + 1);
    n = 0;
    while (pif.sys_rst && n < 100) begin step(0, 1); n++; end
    chk("midrst_relock", pif.ready, 1);

`ifdef PLL_LOCK_TIMEOUT_EN
    // lock never arrives: two retries, then sticky fault
    step(1, 0);
    t1 = -1; t2 = -1; tf = -1;
    for (int k = 1; k <= 200 && tf < 0; k++) begin
      step(0, 0);
      if (pif.retries == 1 && t1 < 0) t1 = k;
      if (pif.retries == 2 && t2 < 0) t2 = k;
      if (pif.fault && tf < 0) tf = k;
    end
    chk("to_retry1_cycle", t1, P + T);
    chk("to_retry2_cycle", t2, 2 * (P + T));
    chk("to_fault_cycle", tf, 3 * (P + T));
    repeat (30) step(0, 1);
    chk("fault_sticky", pif.fault, 1);
    chk("fault_pll_reset", pif.pll_reset, 1);
    chk("fault_sys_rst", pif.sys_rst, 1);
    chk("fault_retries", pif.retries, 2);
    step(1, 0);
    chk("fault_clr_fault", pif.fault, 0);
    chk("fault_clr_retries", pif.retries, 0);
    chk("fault_clr_pll_reset", pif.pll_reset, 1);
`else
    // lock never arrives: wait indefinitely, then a late lock still releases
    step(1, 0);
    repeat (1000) step(0, 0);
    chk("nolock_pll_reset", pif.pll_reset, 0);
    chk("nolock_sys_rst", pif.sys_rst, 1);
    chk("nolock_fault", pif.fault, 0);
    chk("nolock_retries", pif.retries, 0);
    step(0, 1);
    n = 0;
    while (pif.sys_rst && n < 100) begin step(0, 1); n++; end
    chk("late_lock_latency", n, 2 + S);
    t1 = 0; t2 = 0; tf = 0;
`endif

    // randomized lock segments with occasional rst
    step(1, 0);
    cyc = 0;
    while (cyc < 4000) begin
      len = $urandom_range(1, 30);
      lv  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin step(1, lv); cyc++; end
      for (int k = 0; k < len; k++) begin step(0, lv); cyc++; end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences the board's 27 MHz-referenced rPLL (x37/7, ≈142.7 MHz output) from power-up to a clean, stable system reset release. Runs on the free-running crystal clock, drives the PLL's RESET input, synchronizes and debounces its LOCK output, and holds the downstream system reset until lock has been stable for a programmable interval. On lock loss it re-asserts system reset and restarts the PLL, with optional timeout and retry accounting.

## Interface
- `PLL_RESET_CYCLES`, default 32: cycles `pll_reset` is held high per attempt (≥2).
- `STABLE_CYCLES`, default 1024: consecutive synchronized-lock cycles required before release.
- `LOCK_TIMEOUT_CYCLES`, default 27000 (1 ms at 27 MHz): max wait for lock per attempt; used only with the macro.
- `MAX_RETRIES`, default 7: failed attempts before `fault`; used only with the macro.
- `clk`, in, 1: 27 MHz crystal clock; never the PLL output.
- `rst`, in, 1: synchronous, active-high.
- `pll_lock`, in, 1: raw PLL LOCK; asynchronous to `clk`.
- `pll_reset`, out, 1: to PLL RESET, active-high.
- `sys_rst`, out, 1: system reset request, active-high, `clk` domain.
- `ready`, out, 1: high exactly when in RUN.
- `fault`, out, 1: sticky, retries exhausted.
- `retries`, out, 3: failed attempts since `rst`; saturates at 7.

## Operation
- `pll_lock` passes a 2-flop synchronizer; only `lock_s` is used internally.
- States:
  - RESET_PLL: `pll_reset`=1, `sys_rst`=1. Counter runs `PLL_RESET_CYCLES`, then WAIT_LOCK with counter cleared.
  - WAIT_LOCK: `pll_reset`=0. `lock_s`=1 → STABLE with counter cleared. With the macro, the counter reaching `LOCK_TIMEOUT_CYCLES` counts as a failed attempt.
  - STABLE: `lock_s`=0 → WAIT_LOCK with counter cleared; this is not a failed attempt. Counter reaching `STABLE_CYCLES`-1 with `lock_s`=1 → RUN.
  - RUN: `sys_rst`=0, `ready`=1. `lock_s`=0 → RESET_PLL; `sys_rst`=1 in the same cycle as that transition is registered.
  - FAULT: `pll_reset`=1, `sys_rst`=1, `fault`=1. Leaves only on `rst`.
- Failed attempt: if `retries`+1 reaches `MAX_RETRIES`, go to FAULT; otherwise go to RESET_PLL and increment `retries`.
- Lock loss from RUN never increments `retries`.
- A single counter is shared by all states. Its width is `$clog2` of the largest count parameter, +1. No wrap: it is cleared on every state entry.
- `rst` mid-operation returns to RESET_PLL next cycle regardless of state and clears `retries`, `fault` and the synchronizer.

## Timing
- Reset values: `pll_reset`=1, `sys_rst`=1, `ready`=0, `fault`=0, `retries`=0. State is RESET_PLL and the counter is 0.
- All outputs are registered directly from state and flags; there is no combinational path from `pll_lock`.
- Lock latency: `pll_lock` rise → `lock_s` rise takes 2 cycles.
- STABLE → RUN takes `STABLE_CYCLES` cycles of `lock_s`=1.
- From `rst` deassert with an ideal PLL: `pll_reset` falls after `PLL_RESET_CYCLES` cycles. `sys_rst` falls `PLL_RESET_CYCLES` + lock time + 2 + `STABLE_CYCLES` (+1 state register) cycles after.
- Lock loss in RUN: `sys_rst` rises 3 cycles after the `pll_lock` fall (2 sync + 1 register).
- A lock glitch shorter than 1 cycle may be missed. This is accepted; the PLL holds LOCK low for many cycles on a real loss.
- `sys_rst` is in the `clk` domain. Consumers on the PLL clock must re-synchronize it with async-assert / sync-deassert; that logic is not part of this block.

## Configuration
- Macro: `PLL_LOCK_TIMEOUT_EN`.
- Defined: WAIT_LOCK timeout, retry counting and the FAULT state are compiled in.
- Undefined:
  - WAIT_LOCK waits forever.
  - `retries` and `fault` are tied to 0.
  - No FAULT state or timeout comparator is synthesized.
  - `LOCK_TIMEOUT_CYCLES` and `MAX_RETRIES` are ignored.

## Structure
- Shared package `pll_reset_pkg`: state enum (RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT) and the default cycle constants.
- One sub-module: `sync_2ff`, a generic 2-flop synchronizer with a reset value, also reusable elsewhere.
- Top level is the FSM plus counter, retry register and output registers.

## Test plan
- Parameters: `PLL_RESET_CYCLES`=4, `STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=20, `MAX_RETRIES`=3.
- Clean lock: `rst` released, `pll_lock` rises 5 cycles after `pll_reset` falls → `pll_reset` high 4 cycles; `sys_rst` falls 5+2+8 cycles after `pll_reset` falls; `ready`=1; `retries`=0.
- Lock chatter: `pll_lock` high 3 cycles, low 2, then steady → STABLE restarts; `sys_rst` release is measured from the final rise; `retries` stays 0.
- Lock loss in RUN: drop `pll_lock` → `sys_rst`=1 and `ready`=0 3 cycles later; `pll_reset` pulses 4 cycles; relock releases again; `retries`=0.
- Timeout/fault (macro defined): `pll_lock` tied 0 → `retries` steps 1, 2; third timeout → `fault`=1 with `pll_reset`=1 and `sys_rst`=1 held; `rst` pulse clears all.
- No macro: `pll_lock` tied 0 for 1000 cycles → remains in WAIT_LOCK; `fault`=0 and `retries`=0; a late lock still releases normally.
- Mid-sequence reset: assert `rst` for 1 cycle during STABLE → next cycle `pll_reset`=1, `sys_rst`=1, counter restarts from 0.
